// File: rtl/alu_issue.sv
// Three-phase ALU issue stage (IDLE -> ISSUE -> WB) around a 4 x 8-bit register file.
// Operands and opcode go to an external combinational ALU; its result is written back to the register file.
module alu_issue #(
   parameter bit R0_ZERO = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [1:0] instr_op,
   input  logic [1:0] instr_rd,
   input  logic [1:0] instr_rs1,
   input  logic [1:0] instr_rs2,
   input  logic       ld_en,
   input  logic [1:0] ld_addr,
   input  logic [7:0] ld_data,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [1:0] alu_ctrl,
   input  logic [7:0] alu_res,
   output logic       wb_valid,
   output logic [1:0] wb_rd,
   output logic [7:0] wb_data,
   output logic       wb_zero,
   input  logic [1:0] rd_addr,
   output logic [7:0] rd_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

   state_t     state;
   logic [7:0] regs    [4];
   logic [7:0] rf_view [4];
   logic [7:0] result;
   logic [1:0] rd_hold;
   logic       ld_ok;
   logic       wb_ok;

   // Architectural view of the register file: r0 is hard-wired to zero when R0_ZERO is set.
   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         rf_view[i] = (R0_ZERO && i == 0) ? '0 : regs[i];
      end
   end

   assign ld_ok       = !(R0_ZERO && ld_addr == 2'd0);
   assign wb_ok       = !(R0_ZERO && wb_rd == 2'd0);
   assign instr_ready = (state == IDLE);
   assign rd_data     = rf_view[rd_addr];
   assign wb_data     = result;
   assign wb_zero     = (result == 8'h00);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         for (int unsigned i = 0; i < 4; i++) begin
            regs[i] <= '0;
         end
         alu_a    <= '0;
         alu_b    <= '0;
         alu_ctrl <= '0;
         rd_hold  <= '0;
         result   <= '0;
         wb_rd    <= '0;
         wb_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Operands sample rf_view before this edge, so a same-cycle load is not forwarded.
               if (ld_en && ld_ok) begin
                  regs[ld_addr] <= ld_data;
               end
               if (instr_valid) begin
                  alu_a    <= rf_view[instr_rs1];
                  alu_b    <= rf_view[instr_rs2];
                  alu_ctrl <= instr_op;
                  rd_hold  <= instr_rd;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               result   <= alu_res;
               wb_rd    <= rd_hold;
               wb_valid <= 1'b1;
               state    <= WB;
            end
            WB: begin
               if (wb_ok) begin
                  regs[wb_rd] <= result;
               end
               wb_valid <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               wb_valid <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue (R0_ZERO=1): transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_alu_issue;

   localparam bit P_R0 = 1'b1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid;
   logic       instr_ready;
   logic [1:0] instr_op;
   logic [1:0] instr_rd;
   logic [1:0] instr_rs1;
   logic [1:0] instr_rs2;
   logic       ld_en;
   logic [1:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [1:0] alu_ctrl;
   logic [7:0] alu_res;
   logic       wb_valid;
   logic [1:0] wb_rd;
   logic [7:0] wb_data;
   logic       wb_zero;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;

   int vectors     = 0;
   int miscompares = 0;

   alu_issue #(.R0_ZERO(P_R0)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // Downstream ALU
   always_comb alu_res = alu_f(alu_ctrl, alu_a, alu_b);

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: result is computed from register contents at accept time,
   // and the instruction retires two cycles later.
   logic [7:0] m_regs [4];
   int         m_left;
   logic [7:0] m_a, m_b, m_pend, m_wbdata;
   logic [1:0] m_op, m_rd, m_wbrd;
   logic       m_wbv;
   logic       armed = 1'b0;

   function automatic logic [7:0] rv(input logic [1:0] idx);
      return (P_R0 && idx == 2'd0) ? 8'h00 : m_regs[idx];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         armed <= 1'b1;
         for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
         m_left <= 0; m_a <= 8'h00; m_b <= 8'h00; m_op <= 2'd0; m_rd <= 2'd0;
         m_pend <= 8'h00; m_wbv <= 1'b0; m_wbrd <= 2'd0; m_wbdata <= 8'h00;
      end else if (m_left == 0) begin
         if (ld_en && !(P_R0 && ld_addr == 2'd0)) m_regs[ld_addr] <= ld_data;
         if (instr_valid) begin
            m_a    <= rv(instr_rs1);
            m_b    <= rv(instr_rs2);
            m_op   <= instr_op;
            m_rd   <= instr_rd;
            m_pend <= alu_f(instr_op, rv(instr_rs1), rv(instr_rs2));
            m_left <= 2;
         end
      end else if (m_left == 2) begin
         m_left   <= 1;
         m_wbv    <= 1'b1;
         m_wbrd   <= m_rd;
         m_wbdata <= m_pend;
      end else begin
         m_left <= 0;
         m_wbv  <= 1'b0;
         if (!(P_R0 && m_wbrd == 2'd0)) m_regs[m_wbrd] <= m_wbdata;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("ready",    {7'd0, instr_ready}, {7'd0, m_left == 0});
         chk("alu_a",    alu_a, m_a);
         chk("alu_b",    alu_b, m_b);
         chk("alu_ctrl", {6'd0, alu_ctrl}, {6'd0, m_op});
         chk("wb_valid", {7'd0, wb_valid}, {7'd0, m_wbv});
         chk("wb_rd",    {6'd0, wb_rd}, {6'd0, m_wbrd});
         chk("wb_data",  wb_data, m_wbdata);
         chk("wb_zero",  {7'd0, wb_zero}, {7'd0, m_wbdata == 8'h00});
         chk("rd_data",  rd_data, rv(rd_addr));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [1:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      step();
      ld_en = 1'b0;
   endtask

   // Offer one instruction; returns in the WB cycle (accept cycle + 2).
   task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
      instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
      step();
      instr_valid = 1'b0;
      step();
   endtask

   task automatic wb_lit(input string name, input logic [1:0] rd, input logic [7:0] d);
      chk({name, "_wbv"}, {7'd0, wb_valid}, 8'd1);
      chk({name, "_rd"},  {6'd0, wb_rd}, {6'd0, rd});
      chk({name, "_dat"}, wb_data, d);
      chk({name, "_z"},   {7'd0, wb_zero}, {7'd0, d == 8'h00});
   endtask

   initial begin
      rst_n = 1'b0; instr_valid = 1'b1; instr_op = 2'd0; instr_rd = 2'd1;
      instr_rs1 = 2'd0; instr_rs2 = 2'd0; ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h77;
      rd_addr = 2'd1;
      step(); step();
      chk("rst_ready", {7'd0, instr_ready}, 8'd1);
      chk("rst_r1",    rd_data, 8'h00);
      chk("rst_wbz",   {7'd0, wb_zero}, 8'd1);
      chk("rst_wbd",   wb_data, 8'h00);
      rst_n = 1'b1; instr_valid = 1'b0; ld_en = 1'b0;
      #1 chk("rel_ready", {7'd0, instr_ready}, 8'd1);
      step();

      ld(2'd1, 8'h05); ld(2'd2, 8'h03);
      rd_addr = 2'd3;
      issue(2'b00, 2'd3, 2'd1, 2'd2);
      wb_lit("add", 2'd3, 8'h08);
      chk("add_r3_pre", rd_data, 8'h00);
      step();
      chk("add_r3", rd_data, 8'h08);

      ld(2'd1, 8'h03); ld(2'd2, 8'h05);
      issue(2'b01, 2'd3, 2'd1, 2'd2); wb_lit("sub", 2'd3, 8'hFE); step();
      ld(2'd1, 8'hF0); ld(2'd2, 8'h3C);
      issue(2'b10, 2'd3, 2'd1, 2'd2); wb_lit("and", 2'd3, 8'h30); step();
      issue(2'b11, 2'd3, 2'd1, 2'd2); wb_lit("or",  2'd3, 8'hFC); step();

      ld(2'd1, 8'hFF); ld(2'd2, 8'h01);
      rd_addr = 2'd0;
      issue(2'b00, 2'd0, 2'd1, 2'd2); wb_lit("wrap", 2'd0, 8'h00); step();
      chk("r0_after_wb", rd_data, 8'h00);
      issue(2'b00, 2'd0, 2'd2, 2'd2); wb_lit("r0wb", 2'd0, 8'h02); step();
      chk("r0_after_wb2", rd_data, 8'h00);
      ld(2'd0, 8'h55);
      chk("r0_after_ld", rd_data, 8'h00);
      issue(2'b00, 2'd2, 2'd0, 2'd2); wb_lit("r0src", 2'd2, 8'h01); step();

      ld(2'd1, 8'h01);
      rd_addr = 2'd1;
      instr_valid = 1'b1; instr_op = 2'b00; instr_rd = 2'd1; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
      for (int k = 0; k <= 9; k++) begin
         chk($sformatf("b2b_ready%0d", k), {7'd0, instr_ready}, {7'd0, k % 3 == 0});
         if (k > 0 && k % 3 == 0) chk($sformatf("b2b_r1_%0d", k), rd_data, 8'(1 << (k / 3)));
         if (k == 9) instr_valid = 1'b0;
         else step();
      end
      step();

      ld(2'd1, 8'h05); ld(2'd2, 8'h03);
      rd_addr = 2'd2;
      instr_valid = 1'b1; instr_op = 2'b00; instr_rd = 2'd3; instr_rs1 = 2'd2; instr_rs2 = 2'd2;
      step();
      instr_valid = 1'b0; ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA;
      step();
      ld_en = 1'b1;
      wb_lit("ldblk", 2'd3, 8'h06);
      step();
      ld_en = 1'b0;
      chk("ld_ignored", rd_data, 8'h03);

      rd_addr = 2'd1;
      ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h10;
      instr_valid = 1'b1; instr_op = 2'b00; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
      step();
      ld_en = 1'b0; instr_valid = 1'b0;
      chk("same_a",  alu_a, 8'h05);
      chk("same_r1", rd_data, 8'h10);
      step();
      wb_lit("same", 2'd3, 8'h08);
      step();

      rd_addr = 2'd3;
      instr_valid = 1'b1; instr_op = 2'b00; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
      step();
      instr_valid = 1'b0; rst_n = 1'b0;
      step();
      chk("abort_wbv",  {7'd0, wb_valid}, 8'd0);
      chk("abort_a",    alu_a, 8'h00);
      chk("abort_b",    alu_b, 8'h00);
      chk("abort_ctrl", {6'd0, alu_ctrl}, 8'd0);
      chk("abort_wbrd", {6'd0, wb_rd}, 8'd0);
      chk("abort_wbd",  wb_data, 8'h00);
      chk("abort_wbz",  {7'd0, wb_zero}, 8'd1);
      chk("abort_rdy",  {7'd0, instr_ready}, 8'd1);
      rst_n = 1'b1;
      step(); step();
      chk("abort_nowb", {7'd0, wb_valid}, 8'd0);
      chk("abort_r3",   rd_data, 8'h00);

      ld(2'd1, 8'h21);
      issue(2'b00, 2'd3, 2'd1, 2'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("abort_wb_r3", rd_data, 8'h00);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
